// File: rtl/inbuf_arbiter.sv
// Frame-ROM read arbiter: single-beat LCD fetch port (0) shares the ROM
// with a burst line-buffer fill port (1). Port 0 wins arbitration unless a
// pending port-1 beat has lost STARVE_MAX consecutive cycles. Read data is
// routed back through a latency-matched tag pipeline.
module inbuf_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 24,
  parameter int DEPTH      = 76800,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8,
  parameter int LEN_W      = 9
) (
  input  logic              iClk,
  input  logic              iRstButton,
  input  logic              iReq0,
  input  logic [ADDR_W-1:0] iAddr0,
  output logic              oGnt0,
  output logic              oRdValid0,
  output logic [DATA_W-1:0] oRdData0,
  input  logic              iReq1,
  input  logic [ADDR_W-1:0] iBase1,
  input  logic [LEN_W-1:0]  iLen1,
  output logic              oAck1,
  output logic              oRdValid1,
  output logic [DATA_W-1:0] oRdData1,
  output logic              oDone1,
  output logic              oCs,
  output logic [ADDR_W-1:0] oAddr,
  input  logic [DATA_W-1:0] iRomData
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_cnt;
  logic [SW-1:0]     r_starve;
  logic              r_zlen;
  logic              r_done;
  logic [RD_LAT-1:0] r_pv;
  logic [RD_LAT-1:0] r_pp;
  logic [RD_LAT-1:0] r_pl;
  logic [DATA_W-1:0] r_hold0;
  logic [DATA_W-1:0] r_hold1;

  logic              w_pend1;
  logic              w_starved;
  logic              w_issue0;
  logic              w_issue1;
  logic              w_accept;
  logic              w_last1;
  logic              w_drain_exit;
  logic [RD_LAT:0]   w_pv_sh;
  logic [RD_LAT:0]   w_pp_sh;
  logic [RD_LAT:0]   w_pl_sh;
  logic              w_v0;
  logic              w_v1;

  // Per-cycle arbitration between the two ports and burst acceptance
  always_comb begin
    w_pend1   = (r_state == BURST);
    w_starved = (r_starve >= SW'(STARVE_MAX));
    w_issue0  = ~iRstButton & iReq0 & (~w_pend1 | ~w_starved);
    w_issue1  = ~iRstButton & w_pend1 & ~w_issue0;
    w_accept  = ~iRstButton & (r_state == IDLE) & iReq1;
    w_last1   = w_issue1 & (r_cnt == LEN_W'(1));
  end

  // Return tag pipeline: new tag enters at bit 0, the top bit of each
  // shifted vector is the tag whose ROM data is on iRomData this cycle
  always_comb begin
    w_pv_sh      = {r_pv, w_issue0 | w_issue1};
    w_pp_sh      = {r_pp, w_issue1};
    w_pl_sh      = {r_pl, w_last1};
    w_v0         = w_pv_sh[RD_LAT] & ~w_pp_sh[RD_LAT];
    w_v1         = w_pv_sh[RD_LAT] & w_pp_sh[RD_LAT];
    w_drain_exit = (r_state == DRAIN) &
                   (r_zlen | (w_v1 & w_pl_sh[RD_LAT]));
  end

  // Tag pipeline advance; reset discards everything in flight
  always_ff @(posedge iClk) begin
    if (iRstButton) begin
      r_pv <= '0;
      r_pp <= '0;
      r_pl <= '0;
    end else begin
      r_pv <= w_pv_sh[RD_LAT-1:0];
      r_pp <= w_pp_sh[RD_LAT-1:0];
      r_pl <= w_pl_sh[RD_LAT-1:0];
    end
  end

  // Read data hold registers so outputs keep their last returned value
  always_ff @(posedge iClk) begin
    if (iRstButton) begin
      r_hold0 <= '0;
      r_hold1 <= '0;
    end else begin
      if (w_v0) r_hold0 <= iRomData;
      if (w_v1) r_hold1 <= iRomData;
    end
  end

  // Burst pointer, remaining count, starvation counter and done pulse
  always_ff @(posedge iClk) begin
    if (iRstButton) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_zlen   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr  <= iBase1;
        r_cnt  <= iLen1;
        r_zlen <= (iLen1 == '0);
      end else if (w_issue1) begin
        r_ptr <= (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
      if ((r_state == IDLE) || w_issue1) begin
        r_starve <= '0;
      end else if (w_pend1 && w_issue0) begin
        r_starve <= r_starve + 1'b1;
      end
      r_done <= w_drain_exit;
    end
  end

  // FSM state register
  always_ff @(posedge iClk) begin
    if (iRstButton) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (iLen1 == '0) ? DRAIN : BURST;
      BURST:   if (w_last1) w_next = DRAIN;
      DRAIN:   if (w_drain_exit) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    oCs       = w_issue0 | w_issue1;
    oGnt0     = w_issue0;
    oAddr     = w_issue0 ? iAddr0 : (w_issue1 ? r_ptr : '0);
    oAck1     = w_accept;
    oDone1    = r_done;
    oRdValid0 = w_v0;
    oRdValid1 = w_v1;
    oRdData0  = w_v0 ? iRomData : r_hold0;
    oRdData1  = w_v1 ? iRomData : r_hold1;
  end

endmodule

// File: tb/tb_inbuf_arbiter.sv
// Directed bench for inbuf_arbiter: one instance at RD_LAT=1 and one at
// RD_LAT=3 share stimulus; a scoreboard of expected returns (port, data,
// due cycle) is filled on each expected issue and drained on return.
module tb_inbuf_arbiter;

  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [16:0] addr0, base1;
  logic [8:0]  len1;

  logic        a_gnt0, a_v0, a_ack, a_v1, a_done, a_cs;
  logic [23:0] a_d0, a_d1, a_rom;
  logic [16:0] a_addr, a_rp;
  logic        b_gnt0, b_v0, b_ack, b_v1, b_done, b_cs;
  logic [23:0] b_d0, b_d1, b_rom;
  logic [16:0] b_addr, b_rp0, b_rp1, b_rp2;

  logic        sel;
  logic        m_gnt0, m_v0, m_ack, m_v1, m_done, m_cs;
  logic [23:0] m_d0, m_d1;
  logic [16:0] m_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        port;
    logic [23:0] data;
    int          due;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  function automatic logic [23:0] romf(input logic [16:0] a);
    logic [23:0] x;
    x = {7'd0, a};
    return (x * 24'h00C3A5) ^ 24'h5A5A5A;
  endfunction

  // ROM models with 1- and 3-cycle read latency
  always @(posedge clk) begin
    a_rp  <= a_addr;
    b_rp0 <= b_addr;
    b_rp1 <= b_rp0;
    b_rp2 <= b_rp1;
  end
  assign a_rom = romf(a_rp);
  assign b_rom = romf(b_rp2);

  inbuf_arbiter #(.RD_LAT(1)) u_a (
    .iClk(clk), .iRstButton(rst),
    .iReq0(req0), .iAddr0(addr0), .oGnt0(a_gnt0),
    .oRdValid0(a_v0), .oRdData0(a_d0),
    .iReq1(req1), .iBase1(base1), .iLen1(len1), .oAck1(a_ack),
    .oRdValid1(a_v1), .oRdData1(a_d1), .oDone1(a_done),
    .oCs(a_cs), .oAddr(a_addr), .iRomData(a_rom)
  );

  inbuf_arbiter #(.RD_LAT(3)) u_b (
    .iClk(clk), .iRstButton(rst),
    .iReq0(req0), .iAddr0(addr0), .oGnt0(b_gnt0),
    .oRdValid0(b_v0), .oRdData0(b_d0),
    .iReq1(req1), .iBase1(base1), .iLen1(len1), .oAck1(b_ack),
    .oRdValid1(b_v1), .oRdData1(b_d1), .oDone1(b_done),
    .oCs(b_cs), .oAddr(b_addr), .iRomData(b_rom)
  );

  always_comb begin
    if (sel) begin
      m_gnt0 = b_gnt0; m_v0 = b_v0; m_d0 = b_d0; m_ack = b_ack;
      m_v1 = b_v1; m_d1 = b_d1; m_done = b_done; m_cs = b_cs; m_addr = b_addr;
    end else begin
      m_gnt0 = a_gnt0; m_v0 = a_v0; m_d0 = a_d0; m_ack = a_ack;
      m_v1 = a_v1; m_d1 = a_d1; m_done = a_done; m_cs = a_cs; m_addr = a_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Compare return-path outputs against the scoreboard, then move to next cycle
  task automatic advance();
    logic exp_v;
    ent_t e;
    exp_v = (q.size() != 0) && (q[0].due == cyc);
    e.port = 1'b0;
    e.data = '0;
    e.due  = 0;
    if (exp_v) e = q.pop_front();
    chk("rd_valid0", m_v0, exp_v & ~e.port);
    chk("rd_valid1", m_v1, exp_v & e.port);
    if (exp_v) begin
      if (e.port) chk("rd_data1", m_d1, e.data);
      else        chk("rd_data0", m_d0, e.data);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // One cycle: check issue-side outputs, record the expected return
  task automatic step(input string tag, input logic cs, input int addr,
                      input logic gnt0, input logic ack, input logic done);
    ent_t e;
    logic [16:0] a;
    @(negedge clk);
    a = 17'(addr);
    chk({tag, ".cs"}, m_cs, cs);
    if (cs) chk({tag, ".addr"}, m_addr, a);
    chk({tag, ".gnt0"}, m_gnt0, gnt0);
    chk({tag, ".ack1"}, m_ack, ack);
    chk({tag, ".done1"}, m_done, done);
    if (cs) begin
      e.port = ~gnt0;
      e.data = romf(a);
      e.due  = cyc + (sel ? 3 : 1);
      q.push_back(e);
    end
    advance();
  endtask

  task automatic zero_check(input string tag);
    @(negedge clk);
    chk({tag, ".cs"}, m_cs, 0);
    chk({tag, ".addr"}, m_addr, 0);
    chk({tag, ".gnt0"}, m_gnt0, 0);
    chk({tag, ".ack1"}, m_ack, 0);
    chk({tag, ".done1"}, m_done, 0);
    chk({tag, ".data0"}, m_d0, 0);
    chk({tag, ".data1"}, m_d1, 0);
    advance();
  endtask

  initial begin
    int wa [4];
    int left, k, last1;
    logic exp_d;
    logic [31:0] p0pat;

    sel = 1'b0;
    rst = 1'b1; req0 = 1'b1; addr0 = 17'd9; req1 = 1'b1; base1 = '0; len1 = '0;
    @(posedge clk); cyc++; #1;
    // requests while reset is held must not issue or ack
    step("rst_comb", 0, 0, 0, 0, 0);
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    zero_check("rst_state");

    // basic burst of 4 from address 100
    req1 = 1'b1; base1 = 17'd100; len1 = 9'd4;
    step("s1_ack", 0, 0, 0, 1, 0);
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) step("s1_beat", 1, 100 + i, 0, 0, 0);
    step("s1_ret", 0, 0, 0, 0, 0);
    step("s1_done", 0, 0, 0, 0, 1);
    step("s1_idle", 0, 0, 0, 0, 0);

    // zero-length burst; request in DRAIN is not acked
    req1 = 1'b1; base1 = 17'd50; len1 = 9'd0;
    step("s4_ack", 0, 0, 0, 1, 0);
    step("s4_drain_req", 0, 0, 0, 0, 0);
    req1 = 1'b0;
    step("s4_done", 0, 0, 0, 0, 1);
    step("s4_idle", 0, 0, 0, 0, 0);

    // pointer wrap at DEPTH-1
    req1 = 1'b1; base1 = 17'd76798; len1 = 9'd4;
    step("s3_ack", 0, 0, 0, 1, 0);
    req1 = 1'b0;
    wa = '{76798, 76799, 0, 1};
    for (int i = 0; i < 4; i++) step("s3_beat", 1, wa[i], 0, 0, 0);
    step("s3_ret", 0, 0, 0, 0, 0);
    step("s3_done", 0, 0, 0, 0, 1);
    step("s3_idle", 0, 0, 0, 0, 0);

    // port 0 held busy during a 20-beat burst: 8 port-0 grants then 1 port-1 beat
    req0 = 1'b1; addr0 = 17'd5; req1 = 1'b1; base1 = 17'd200; len1 = 9'd20;
    step("s2_ack", 1, 5, 1, 1, 0);
    req1 = 1'b0;
    for (int b = 0; b < 20; b++) begin
      for (int j = 0; j < 8; j++) begin
        req1 = (b == 0);
        step("s2_p0", 1, 5, 1, 0, 0);
      end
      req1 = 1'b0;
      step("s2_p1", 1, 200 + b, 0, 0, 0);
    end
    step("s2_drain", 1, 5, 1, 0, 0);
    step("s2_done", 1, 5, 1, 0, 1);
    req0 = 1'b0;
    step("s2_idle", 0, 0, 0, 0, 0);
    step("s2_idle2", 0, 0, 0, 0, 0);

    // reset after 3 beats of a 10-beat burst
    req1 = 1'b1; base1 = 17'd300; len1 = 9'd10;
    step("s5_ack", 0, 0, 0, 1, 0);
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) step("s5_beat", 1, 300 + i, 0, 0, 0);
    rst = 1'b1; req0 = 1'b1; addr0 = 17'd7;
    step("s5_rst", 0, 0, 0, 0, 0);
    rst = 1'b0; req0 = 1'b0;
    q.delete();
    zero_check("s5_after");
    for (int i = 0; i < 3; i++) step("s5_quiet", 0, 0, 0, 0, 0);
    req1 = 1'b1; base1 = 17'd10; len1 = 9'd2;
    step("s5_ack2", 0, 0, 0, 1, 0);
    req1 = 1'b0;
    step("s5_beat2", 1, 10, 0, 0, 0);
    step("s5_beat2", 1, 11, 0, 0, 0);
    step("s5_ret2", 0, 0, 0, 0, 0);
    step("s5_done2", 0, 0, 0, 0, 1);
    step("s5_idle2", 0, 0, 0, 0, 0);
    chk("a_sb_empty", q.size(), 0);

    // RD_LAT=3 instance with mixed port-0 / port-1 traffic
    rst = 1'b1;
    step("b_rst", 0, 0, 0, 0, 0);
    q.delete();
    sel = 1'b1;
    rst = 1'b0;
    zero_check("b_rst_state");
    p0pat = 32'h0000_169A;
    req0 = 1'b1; addr0 = 17'd40; req1 = 1'b1; base1 = 17'd1000; len1 = 9'd6;
    step("b_ack", 1, 40, 1, 1, 0);
    req1 = 1'b0;
    left = 6; k = 0; last1 = -100;
    for (int c = 1; c <= 20; c++) begin
      req0  = p0pat[c];
      addr0 = 17'(40 + 7 * c);
      exp_d = (c == last1 + 4);
      if (req0) begin
        step("b_p0", 1, 40 + 7 * c, 1, 0, exp_d);
      end else if (left > 0) begin
        step("b_p1", 1, 1000 + k, 0, 0, exp_d);
        if (left == 1) last1 = c;
        k++;
        left--;
      end else begin
        step("b_idle", 0, 0, 0, 0, exp_d);
      end
    end
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) step("b_flush", 0, 0, 0, 0, 0);
    chk("b_sb_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
